// File: rtl/im_loader_pkg.sv
// im_loader_pkg: shared definitions for the boot-time instruction-memory loader.
//   state_t        : loader FSM state encoding (also exported on state_dbg)
//   IM_BASE        : fetch address that maps to instruction-memory byte 0
//   ADDR_W_DEFAULT : default byte-address width of the instruction memory
package im_loader_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEN_HI = 3'd1,
      LEN_LO = 3'd2,
      DATA   = 3'd3,
      CSUM   = 3'd4,
      FLUSH  = 3'd5,
      DONE   = 3'd6,
      ERR    = 3'd7
   } state_t;

   localparam logic [31:0] IM_BASE        = 32'h0000_3000;
   localparam int          ADDR_W_DEFAULT = 10;

endpackage

// File: rtl/im_loader.sv
// im_loader: boot-time program loader for the single-cycle MIPS datapath.
// Receives a length-prefixed byte stream (L[15:8], L[7:0], L payload bytes,
// optional checksum byte) and writes payload byte k to instruction-memory
// byte address k. The fetch unit is held in reset until a session completes.
//
// Optional feature: define IM_LOADER_CSUM_EN to require a trailing checksum
// byte; the session passes when (sum of payload + checksum) mod 256 == 0.
//
// Handshake: a byte transfers on a rising clk edge where rx_valid && rx_ready.
// rx_ready depends only on the FSM state, never on rx_valid; the sender may
// drop rx_valid at any time and the loader simply waits.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   start             single-cycle pulse beginning a session (IDLE/DONE/ERR only)
//   rx_data/rx_valid  incoming stream byte and its valid
//   rx_ready          loader accepts a byte this cycle
//   im_we/im_addr/im_wdata  registered byte write to instruction memory
//   cpu_hold          fetch-unit reset, low only after a successful session
//   done / err        level status of the last session
//   state_dbg         current FSM state (im_loader_pkg::state_t encoding)
module im_loader
   import im_loader_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [7:0]        im_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              err,
   output logic [2:0]        state_dbg
);

   // Largest legal payload length: the whole memory.
   localparam logic [16:0] MAX_LEN = 17'd1 << ADDR_W;

`ifdef IM_LOADER_CSUM_EN
   localparam state_t AFTER_DATA = CSUM;
`else
   localparam state_t AFTER_DATA = FLUSH;
`endif

   state_t            state, state_nxt;
   logic [7:0]        len_hi;
   logic [ADDR_W:0]   len;
   logic [ADDR_W:0]   cnt;
   logic [ADDR_W:0]   cnt_inc;
   logic [15:0]       len_full;
   logic              len_bad;
   logic              xfer;
   logic              start_ok;

   assign xfer      = rx_valid && rx_ready;
   assign len_full  = {len_hi, rx_data};
   assign len_bad   = ({1'b0, len_full} > MAX_LEN) || (len_full[1:0] != 2'b00);
   assign cnt_inc   = cnt + {{ADDR_W{1'b0}}, 1'b1};
   assign start_ok  = start && ((state == IDLE) || (state == DONE) || (state == ERR));
   assign state_dbg = state;

`ifdef IM_LOADER_CSUM_EN
   logic [7:0] acc;
   logic       csum_ok;
   assign csum_ok = ((acc + rx_data) == 8'h00);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         acc <= 8'h00;
      else if (start_ok)
         acc <= 8'h00;
      else if (state == DATA && xfer)
         acc <= acc + rx_data;
   end
`endif

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next state and state-decoded outputs
   always_comb begin
      state_nxt = state;
      rx_ready  = 1'b0;
      cpu_hold  = 1'b1;
      done      = 1'b0;
      err       = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = LEN_HI;
         end
         LEN_HI: begin
            rx_ready = 1'b1;
            if (rx_valid) state_nxt = LEN_LO;
         end
         LEN_LO: begin
            rx_ready = 1'b1;
            if (rx_valid) begin
               if (len_bad)
                  state_nxt = ERR;
               else if (len_full == 16'd0)
                  state_nxt = AFTER_DATA;
               else
                  state_nxt = DATA;
            end
         end
         DATA: begin
            rx_ready = 1'b1;
            if (rx_valid && (cnt_inc == len)) state_nxt = AFTER_DATA;
         end
         CSUM: begin
`ifdef IM_LOADER_CSUM_EN
            rx_ready = 1'b1;
            if (rx_valid) state_nxt = csum_ok ? FLUSH : ERR;
`else
            state_nxt = IDLE;
`endif
         end
         // One cycle so the last registered write lands before release.
         FLUSH: begin
            state_nxt = DONE;
         end
         DONE: begin
            cpu_hold = 1'b0;
            done     = 1'b1;
            if (start) state_nxt = LEN_HI;
         end
         ERR: begin
            err = 1'b1;
            if (start) state_nxt = LEN_HI;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Length capture, byte counter and registered memory write port
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len_hi   <= 8'h00;
         len      <= '0;
         cnt      <= '0;
         im_we    <= 1'b0;
         im_addr  <= '0;
         im_wdata <= 8'h00;
      end else begin
         im_we <= 1'b0;
         if (state == LEN_HI && xfer)
            len_hi <= rx_data;
         if (state == LEN_LO && xfer) begin
            // Only meaningful when the length passed the check, in which
            // case it fits in ADDR_W+1 bits.
            len <= len_full[ADDR_W:0];
            cnt <= '0;
         end
         if (state == DATA && xfer) begin
            im_we    <= 1'b1;
            im_addr  <= cnt[ADDR_W-1:0];
            im_wdata <= rx_data;
            cnt      <= cnt_inc;
         end
      end
   end

endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: self-checking bench for im_loader.
// Frames are described by length and payload; a reference model decides
// from the framing rules which writes must appear and whether the session
// ends in done or err. Expected writes go into exp_q; a negedge monitor
// pops and compares each im_we pulse and keeps a shadow memory image.
// Optional feature macro: IM_LOADER_CSUM_EN (checksum byte appended).
module tb_im_loader;
   import im_loader_pkg::*;

   localparam int AW = 10;
   localparam int W  = AW + 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic          im_we;
   logic [AW-1:0] im_addr;
   logic [7:0]    im_wdata;
   logic          cpu_hold;
   logic          done;
   logic          err;
   logic [2:0]    state_dbg;

   im_loader #(.ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
      .cpu_hold(cpu_hold), .done(done), .err(err), .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int wr_cnt   = 0;
   logic [AW-1:0] last_addr;
   logic [W-1:0]  exp_q[$];
   logic [7:0]    shadow [0:(1<<AW)-1];
   logic [7:0]    pay    [0:(1<<AW)-1];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (!reset && im_we) begin
         logic [W-1:0] e;
         wr_cnt++;
         last_addr = im_addr;
         shadow[im_addr] = im_wdata;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", im_addr, im_wdata);
         end else begin
            e = exp_q.pop_front();
            if ({im_addr, im_wdata} !== e) begin
               n_fail++;
               $display("FAIL write: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                        im_addr, im_wdata, e[W-1:8], e[7:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Presents one byte, optionally after random idle cycles, and returns
   // 1 ns after the edge on which it was accepted.
   task automatic send_byte(input logic [7:0] b, input int gap_pct);
      int n;
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
         rx_valid = 1'b0;
         @(posedge clk); #1;
      end
      rx_data  = b;
      rx_valid = 1'b1;
      n = 0;
      while (!rx_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!rx_ready) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   // Full session. csum < 0 means "send the correct checksum".
   task automatic send_frame(input int len, input int gap_pct, input int csum);
      int   sum;
      logic len_ok;
      logic exp_done;
      logic [7:0] cbyte;
      pulse_start();
      check("start_rx_ready", 32'(rx_ready), 32'd1);
      check("start_clears_done", 32'(done), 32'd0);
      check("start_clears_err", 32'(err), 32'd0);
      len_ok = (len <= (1 << AW)) && (len % 4 == 0);
      sum = 0;
      for (int k = 0; k < len; k++) sum += pay[k];
      cbyte = (csum < 0) ? 8'((256 - (sum % 256)) % 256) : 8'(csum);
      if (len_ok)
         for (int k = 0; k < len; k++) exp_q.push_back({AW'(k), pay[k]});
      send_byte(8'(len >> 8), gap_pct);
      send_byte(8'(len), gap_pct);
      if (!len_ok) begin
         check("badlen_err", 32'(err), 32'd1);
         check("badlen_hold", 32'(cpu_hold), 32'd1);
         check("badlen_state", 32'(state_dbg), 32'(ERR));
         @(posedge clk); #1;
         check("badlen_no_done", 32'(done), 32'd0);
         return;
      end
      for (int k = 0; k < len; k++) send_byte(pay[k], gap_pct);
`ifdef IM_LOADER_CSUM_EN
      send_byte(cbyte, gap_pct);
      exp_done = (((sum + cbyte) % 256) == 0);
`else
      exp_done = 1'b1;
      if (len > 0) begin
         check("last_we", 32'(im_we), 32'd1);
         check("last_addr", 32'(im_addr), 32'(len - 1));
      end
`endif
      check("t1_hold", 32'(cpu_hold), 32'd1);
      check("t1_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      check("t2_done", 32'(done), 32'(exp_done));
      check("t2_err", 32'(err), 32'(!exp_done));
      check("t2_hold", 32'(cpu_hold), 32'(!exp_done));
      check("t2_no_ready", 32'(rx_ready), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int w0;
      logic [7:0] prog [0:7];
      reset = 1'b1; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_state", 32'(state_dbg), 32'(IDLE));
      check("rst_rx_ready", 32'(rx_ready), 32'd0);
      check("rst_im_we", 32'(im_we), 32'd0);
      check("rst_im_addr", 32'(im_addr), 32'd0);
      check("rst_im_wdata", 32'(im_wdata), 32'd0);
      check("rst_hold", 32'(cpu_hold), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Directed 8-byte program, back-to-back.
      prog = '{8'h3C, 8'h01, 8'h00, 8'h10, 8'h10, 8'h00, 8'hFF, 8'hFF};
      for (int k = 0; k < 8; k++) pay[k] = prog[k];
      send_frame(8, 0, -1);
      check("fetch_word0", {shadow[0], shadow[1], shadow[2], shadow[3]}, 32'h3C010010);
      check("fetch_word1", {shadow[4], shadow[5], shadow[6], shadow[7]}, 32'h1000FFFF);

      // Illegal lengths: no writes expected (monitor flags any).
      send_frame(6, 0, -1);
      send_frame(16'h0404, 0, -1);
      send_frame(($urandom_range(1, 500) * 4) + 1, 0, -1);

      // Same program with random valid gaps.
      w0 = wr_cnt;
      send_frame(8, 40, -1);
      check("gap_write_count", 32'(wr_cnt - w0), 32'd8);
      check("gap_fetch_word0", {shadow[0], shadow[1], shadow[2], shadow[3]}, 32'h3C010010);

      // Random-length legal frames, including empty.
      for (int f = 0; f < 4; f++) begin
         for (int k = 0; k < 64; k++) pay[k] = 8'($urandom);
         send_frame((f == 0) ? 0 : $urandom_range(1, 16) * 4, 20, -1);
      end

      // Full memory.
      for (int k = 0; k < (1 << AW); k++) pay[k] = 8'($urandom);
      send_frame(1 << AW, 0, -1);
      check("full_last_addr", 32'(last_addr), 32'h3FF);

      // Reset in the middle of DATA after 3 bytes.
      for (int k = 0; k < 8; k++) pay[k] = 8'($urandom);
      pulse_start();
      for (int k = 0; k < 8; k++) exp_q.push_back({AW'(k), pay[k]});
      send_byte(8'h00, 0);
      send_byte(8'h08, 0);
      for (int k = 0; k < 3; k++) send_byte(pay[k], 0);
      @(posedge clk); #1;
      check("mid_state_data", 32'(state_dbg), 32'(DATA));
      reset = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_state", 32'(state_dbg), 32'(IDLE));
      check("mid_rst_hold", 32'(cpu_hold), 32'd1);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_err", 32'(err), 32'd0);
      check("mid_rst_pending", 32'(exp_q.size()), 32'd5);
      exp_q.delete();
      reset = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < 8; k++) pay[k] = prog[k];
      send_frame(8, 0, -1);
      check("after_rst_word0", {shadow[0], shadow[1], shadow[2], shadow[3]}, 32'h3C010010);

`ifdef IM_LOADER_CSUM_EN
      pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay[3] = 8'h04;
      send_frame(4, 0, 8'hF6);
      send_frame(4, 0, 8'hF7);
      send_frame(0, 0, 8'h00);
      send_frame(0, 0, 8'h01);
`endif

      repeat (3) @(posedge clk);
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time bound.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/im_loader.md
# im_loader

Boot-time program loader for the single-cycle MIPS datapath: it writes the instruction memory that the fetch unit reads. It receives a length-prefixed byte stream over a valid/ready handshake and writes each payload byte into the byte-wide instruction memory in big-endian word order (byte at address A is instruction bits 31:24). It holds the fetch unit in reset until a session completes. Fetch address 0x0000_3000 maps to memory byte 0, so the loader always writes from byte address 0.

## Interface
- ADDR_W, 10, byte-address width of instruction memory (depth 2^ADDR_W bytes)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  single-cycle pulse that begins a load session
- rx_data  in  8  stream byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader can accept a byte
- im_we  out  1  instruction-memory byte write enable
- im_addr  out  ADDR_W  write byte address
- im_wdata  out  8  write byte
- cpu_hold  out  1  drive fetch-unit reset; high while no valid program is loaded
- done  out  1  last session completed successfully
- err  out  1  last session failed

## Operation
- A byte transfers on a rising edge where rx_valid && rx_ready.
- FSM states and transitions:
  - IDLE: start goes to LEN_HI.
  - LEN_HI: on a transfer, go to LEN_LO.
  - LEN_LO: on a transfer, go to DATA, or to FLUSH if L == 0.
  - DATA: after L transfers, go to CSUM if enabled, otherwise FLUSH.
  - FLUSH: one cycle, then DONE.
  - DONE and ERR: start goes to LEN_HI.
- Frame format: L[15:8], then L[7:0] (payload length in bytes), then L payload bytes, then an optional checksum byte.
- rx_ready is 1 in LEN_HI, LEN_LO, DATA and CSUM. It is 0 in all other states.
- Length check happens on the LEN_LO transfer. If L > 2^ADDR_W or L[1:0] != 0, the FSM goes to ERR and no memory is written.
- Payload byte k (k = 0..L-1) is written to im_addr = k. The byte counter is ADDR_W+1 bits wide and does not wrap.
- start is ignored in LEN_HI, LEN_LO, DATA, CSUM and FLUSH.
- Output levels per state:
  - cpu_hold = 1 everywhere except DONE.
  - done = 1 only in DONE.
  - err = 1 only in ERR.
- In ERR, memory contents are undefined and the CPU stays held.
- Reset mid-session: the FSM returns to IDLE immediately. cpu_hold = 1, done = 0 and err = 0. Partially written memory is not cleared.

## Timing
- Reset values:
  - state IDLE
  - rx_ready 0, im_we 0, im_addr 0, im_wdata 0
  - cpu_hold 1, done 0, err 0
- Start latency: start is sampled at edge t. rx_ready = 1 in the cycle after t.
- Write latency is 1 cycle. A payload byte accepted at edge t produces im_we = 1 with im_addr/im_wdata registered during cycle t+1. im_we is a single-cycle pulse per byte.
- Completion: the final payload byte (or the checksum byte) is accepted at edge t.
  - The last im_we occurs in cycle t+1 (payload case).
  - FLUSH guarantees the final write has committed before release.
  - done = 1 and cpu_hold = 0 from cycle t+2.
- Back-to-back transfers run at one byte per cycle. rx_valid may drop at any time and the FSM simply waits in its state.
- err and done are level outputs. They are cleared on the edge that accepts a new start.

## Configuration
- IM_LOADER_CSUM_EN defined:
  - After the payload, the FSM enters CSUM and accepts one checksum byte.
  - Pass when (sum of all payload bytes + checksum byte) mod 256 == 0x00, going to FLUSH.
  - Fail otherwise, going to ERR.
  - The accumulator is 8 bits and clears on start.
  - For L == 0, the checksum byte is still required and must be 0x00.
- IM_LOADER_CSUM_EN undefined: the CSUM state and accumulator do not exist. DATA goes directly to FLUSH.

## Structure
- Package im_loader_pkg holds:
  - the state enum (IDLE, LEN_HI, LEN_LO, DATA, CSUM, FLUSH, DONE, ERR)
  - IM_BASE = 32'h0000_3000
  - the default ADDR_W
- Single module, no sub-module. The checksum accumulator is a few lines, guarded by the macro.

## Test plan
- Frame 00 08, 3C 01 00 10, 10 00 FF FF, at one byte per cycle: writes addr 0..7 with those bytes in order; the 32-bit fetch at IM byte 0 reads 0x3C010010; done = 1 and cpu_hold = 0 two cycles after the last accept.
- Length 00 06 (not a multiple of 4): ERR in the cycle after the LEN_LO accept; err = 1, cpu_hold = 1, no im_we pulses.
- Length 04 04 with ADDR_W = 10: err = 1. Length 04 00 followed by 1024 bytes: last write at addr 0x3FF, then done.
- Random rx_valid gaps during an 8-byte payload: same memory image and ordering as the gap-free run, with one im_we per accepted byte.
- Assert reset during DATA after 3 bytes: next cycle state IDLE, cpu_hold = 1, done = 0, err = 0; a following full frame loads correctly.
- With IM_LOADER_CSUM_EN, payload 01 02 03 04:
  - checksum F6 gives done;
  - checksum F7 gives err = 1 and cpu_hold = 1.
